// File: rtl/sort_pkg.sv
// Shared types and width helpers for the bubble sort controller.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_N     = 32;
  localparam int unsigned DEF_DEPTH = 8;

  // Width of an index into a DEPTH-entry array (at least one bit)
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must reach DEPTH itself
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Load/drain streaming handshake bundle for the bubble sort controller.
interface bubble_sort_ctrl_if
  import sort_pkg::*;
#(
  parameter int unsigned N = DEF_N
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  // Sorter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/slt.sv
// Combinational signed less-than: lt_o = (a_i < b_i) in two's complement.
module slt #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         lt_o
);

  logic [N:0] diff;

  // Sign-extend by one bit so the difference never overflows; its sign is the answer
  assign diff = {a_i[N-1], a_i} - {b_i[N-1], b_i};
  assign lt_o = diff[N];

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Batch bubble sorter: load DEPTH signed words, sort in place one compare per
// cycle with a single shared comparator, then stream them out ascending.
module bubble_sort_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bubble_sort_ctrl_if.slave            bus,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   pass_count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned PC_W  = cnt_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 2);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  idx_q, idx_d;
  logic              swapped_q, swapped_d;
  logic [PC_W-1:0]   pass_q, pass_d;
  logic [N-1:0]      mem_q [DEPTH];

  logic              ld_we_c;
  logic              swap_we_c;
  logic [PTR_W-1:0]  idx_nx_c;
  logic [N-1:0]      a_c;
  logic [N-1:0]      b_c;
  logic              lt_c;

  // Adjacent pair under comparison this SORT cycle
  assign idx_nx_c = idx_q + 1'b1;
  assign a_c      = mem_q[idx_nx_c];
  assign b_c      = mem_q[idx_q];

  slt #(.N(N)) u_slt (
    .a_i  (a_c),
    .b_i  (b_c),
    .lt_o (lt_c)
  );

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      idx_q     <= '0;
      swapped_q <= 1'b0;
      pass_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      idx_q     <= idx_d;
      swapped_q <= swapped_d;
      pass_q    <= pass_d;
    end
  end

  // Next-state logic: load, one compare/swap per cycle, then drain
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    idx_d     = idx_q;
    swapped_d = swapped_q;
    pass_d    = pass_q;
    ld_we_c   = 1'b0;
    swap_we_c = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          ld_we_c = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            state_d   = SORT;
            wr_ptr_d  = '0;
            idx_d     = '0;
            swapped_d = 1'b0;
            pass_d    = PC_W'(1);
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      SORT: begin
        swap_we_c = lt_c;
        if (idx_q != LAST_IDX) begin
          idx_d     = idx_nx_c;
          swapped_d = swapped_q | lt_c;
        end else if (swapped_q | lt_c) begin
          idx_d     = '0;
          swapped_d = 1'b0;
          pass_d    = pass_q + 1'b1;
        end else begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (rd_ptr_q == LAST_PTR) begin
            state_d  = LOAD;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Data array: loaded from the input stream or swapped in place; no reset needed
  always_ff @(posedge clk) begin
    if (ld_we_c) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end else if (swap_we_c) begin
      mem_q[idx_q]    <= a_c;
      mem_q[idx_nx_c] <= b_c;
    end
  end

  // Outputs decoded from registered state only; out_data gated so reset shows zero
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = (state_q == DRAIN) ? mem_q[rd_ptr_q] : '0;
  assign busy          = (state_q != LOAD);
  assign pass_count    = pass_q;

endmodule
